pkt_stream_tx: RTL and testbench

- Software-loaded packet source. Drives the NetFPGA-style 64-bit data/ctrl stream (data, ctrl, wr, rdy) into the input side of the pipeline datapath's FIFO.
- Packet words are written into an internal word buffer through a load port fed from software registers.
- A start command replays the buffered packet REPEAT times, with a programmable inter-packet gap.
- Used as the stimulus end of the stream protocol for on-board bring-up of the FIFO/CPU path.

---
 rtl/pkt_stream_tx_if.sv | 14 +
 rtl/pkt_stream_tx.sv | 127 ++++++++++++
 tb/tb_pkt_stream_tx.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pkt_stream_tx_if.sv
// Stream interface carrying the NetFPGA-style 64-bit data/ctrl words with a
// wr/rdy handshake from a packet source to the downstream FIFO.
interface pkt_stream_tx_if #(
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = DATA_WIDTH / 8
);
    logic [DATA_WIDTH-1:0] data;
    logic [CTRL_WIDTH-1:0] ctrl;
    logic                  wr;
    logic                  rdy;

    modport master (output data, output ctrl, output wr, input rdy);
    modport slave  (input data, input ctrl, input wr, output rdy);
endinterface

// File: rtl/pkt_stream_tx.sv
// Software-loaded packet source: replays a buffered packet a programmable
// number of times onto the data/ctrl stream with a programmable inter-packet gap.
module pkt_stream_tx #(
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = DATA_WIDTH / 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ld_we,
    input  logic [ADDR_WIDTH-1:0] ld_addr,
    input  logic [DATA_WIDTH-1:0] ld_data,
    input  logic [CTRL_WIDTH-1:0] ld_ctrl,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   pkt_len,
    input  logic [15:0]           repeat_cnt,
    input  logic [7:0]            ipg,
    pkt_stream_tx_if.master       stream,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [31:0]           pkts_sent
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] MAX_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};

    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] mem_data [DEPTH];
    logic [CTRL_WIDTH-1:0] mem_ctrl [DEPTH];
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH-1:0] word_cnt;
    logic [ADDR_WIDTH-1:0] len_m1;
    logic [15:0]           pkt_cnt;
    logic [15:0]           rep_m1;
    logic [7:0]            ipg_r;
    logic [7:0]            gap_cnt;
    logic                  len_ok;

    // NOTE: the packet buffer has no reset; a reset term would stop it mapping to RAM.
    always_ff @(posedge clk) begin
        if (ld_we) begin
            mem_data[ld_addr] <= ld_data;
            mem_ctrl[ld_addr] <= ld_ctrl;
        end
    end

    // Asynchronous read: a word rewritten during transmission goes out with its new value.
    assign stream.data = mem_data[rd_ptr];
    assign stream.ctrl = mem_ctrl[rd_ptr];
    assign stream.wr   = (state == SEND) && stream.rdy;

    assign len_ok = (pkt_len != '0) && (pkt_len <= MAX_LEN);

    // NOTE: all state updates use non-blocking assignments so every branch sees pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            rd_ptr    <= '0;
            word_cnt  <= '0;
            len_m1    <= '0;
            pkt_cnt   <= '0;
            rep_m1    <= '0;
            ipg_r     <= '0;
            gap_cnt   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            pkts_sent <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (len_ok) begin
                            len_m1   <= ADDR_WIDTH'(pkt_len - 1'b1);
                            rep_m1   <= (repeat_cnt == 16'd0) ? 16'd0 : repeat_cnt - 16'd1;
                            ipg_r    <= ipg;
                            rd_ptr   <= '0;
                            word_cnt <= '0;
                            pkt_cnt  <= '0;
                            err      <= 1'b0;
                            busy     <= 1'b1;
                            state    <= SEND;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end

                SEND: begin
                    if (stream.rdy) begin
                        if (word_cnt == len_m1) begin
                            // End of packet: the next packet always restarts at word 0.
                            word_cnt  <= '0;
                            rd_ptr    <= '0;
                            pkt_cnt   <= pkt_cnt + 16'd1;
                            pkts_sent <= pkts_sent + 32'd1;
                            if (pkt_cnt == rep_m1) begin
                                state <= IDLE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end else if (ipg_r != 8'd0) begin
                                gap_cnt <= ipg_r;
                                state   <= GAP;
                            end
                        end else begin
                            word_cnt <= word_cnt + 1'b1;
                            rd_ptr   <= rd_ptr + 1'b1;
                        end
                    end
                end

                GAP: begin
                    gap_cnt <= gap_cnt - 8'd1;
                    if (gap_cnt == 8'd1) begin
                        rd_ptr <= '0;
                        state  <= SEND;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pkt_stream_tx.sv
// Self-checking bench for pkt_stream_tx: directed scenarios plus randomized
// packets and backpressure compared against a packet-level reference model.
module tb_pkt_stream_tx;
    localparam int DW    = 64;
    localparam int CW    = 8;
    localparam int AW    = 8;
    localparam int DEPTH = 256;

    logic          clk;
    logic          reset;
    logic          ld_we;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_data;
    logic [CW-1:0] ld_ctrl;
    logic          start;
    logic [AW:0]   pkt_len;
    logic [15:0]   repeat_cnt;
    logic [7:0]    ipg;
    logic          busy;
    logic          done;
    logic          err;
    logic [31:0]   pkts_sent;

    pkt_stream_tx_if #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW)) stream_if ();

    pkt_stream_tx #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .ld_we      (ld_we),
        .ld_addr    (ld_addr),
        .ld_data    (ld_data),
        .ld_ctrl    (ld_ctrl),
        .start      (start),
        .pkt_len    (pkt_len),
        .repeat_cnt (repeat_cnt),
        .ipg        (ipg),
        .stream     (stream_if),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .pkts_sent  (pkts_sent)
    );

    // Reference copy of the packet buffer and expected packet counter.
    logic [DW-1:0] tb_data [DEPTH];
    logic [CW-1:0] tb_ctrl [DEPTH];
    int            pkts_exp;
    int            checks;
    int            failures;
    logic [6:0]    pat;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic load_word(input int addr, input logic [DW-1:0] d, input logic [CW-1:0] c);
        @(negedge clk);
        ld_we   = 1'b1;
        ld_addr = AW'(addr);
        ld_data = d;
        ld_ctrl = c;
        tb_data[addr] = d;
        tb_ctrl[addr] = c;
        @(negedge clk);
        ld_we = 1'b0;
    endtask

    // mode 0: rdy always 1, 1: random rdy, 2: fixed rdy pattern then 1.
    task automatic run(input int len, input int rep, input int ipg_v, input int mode);
        int            n_rep;
        int            n_exp;
        int            got;
        int            bound;
        bit            done_seen;
        logic [DW-1:0] exp_d [$];
        logic [CW-1:0] exp_c [$];
        int            exp_pos [$];

        n_rep = (rep == 0) ? 1 : rep;
        for (int p = 0; p < n_rep; p++) begin
            for (int w = 0; w < len; w++) begin
                exp_d.push_back(tb_data[w]);
                exp_c.push_back(tb_ctrl[w]);
                exp_pos.push_back(p * (len + ipg_v) + w);
            end
        end
        n_exp = n_rep * len;
        bound = 4 * n_exp + n_rep * ipg_v + 50;

        @(negedge clk);
        pkt_len    = 9'(len);
        repeat_cnt = 16'(rep);
        ipg        = 8'(ipg_v);
        start      = 1'b1;
        got        = 0;
        done_seen  = 1'b0;
        for (int cyc = 0; cyc < bound && !done_seen; cyc++) begin
            @(negedge clk);
            // A start (even an invalid one) while busy must be ignored.
            start = (cyc == 2) && (n_exp >= 4);
            if (start) pkt_len = '0;
            case (mode)
                0:       stream_if.rdy = 1'b1;
                1:       stream_if.rdy = 1'($urandom_range(0, 1));
                default: stream_if.rdy = (cyc < 7) ? pat[cyc] : 1'b1;
            endcase
            #1;
            if (cyc == 0) begin
                check("busy_first", busy, 1'b1);
                check("err_cleared", err, 1'b0);
            end
            if (!stream_if.rdy) check("wr_while_stalled", stream_if.wr, 1'b0);
            if (stream_if.wr === 1'b1) begin
                if (got < n_exp) begin
                    check("data", stream_if.data, exp_d[got]);
                    check("ctrl", stream_if.ctrl, exp_c[got]);
                    if (mode == 0) check("word_cycle", 64'(cyc), 64'(exp_pos[got]));
                end else begin
                    check("extra_word", 1'b1, 1'b0);
                end
                got++;
            end
            if (done === 1'b1) begin
                done_seen = 1'b1;
                check("word_count", 64'(got), 64'(n_exp));
                check("busy_at_done", busy, 1'b0);
                if (mode == 0)
                    check("done_cycle", 64'(cyc), 64'(n_rep * len + (n_rep - 1) * ipg_v));
            end
        end
        start = 1'b0;
        if (!done_seen) check("done_timeout", 1'b0, 1'b1);
        pkts_exp += n_rep;
        check("pkts_sent", pkts_sent, 64'(pkts_exp));
        check("err_after_run", err, 1'b0);
        @(negedge clk);
        stream_if.rdy = 1'b1;
        #1;
        check("done_single", done, 1'b0);
        check("busy_idle", busy, 1'b0);
        check("wr_idle", stream_if.wr, 1'b0);
    endtask

    task automatic bad_start(input int len);
        @(negedge clk);
        pkt_len       = 9'(len);
        repeat_cnt    = 16'd1;
        ipg           = 8'd0;
        stream_if.rdy = 1'b1;
        start         = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        check("err_set", err, 1'b1);
        check("busy_rejected", busy, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check("wr_rejected", stream_if.wr, 1'b0);
        end
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        pkts_exp      = 0;
        pat           = 7'b1011001;
        reset         = 1'b1;
        ld_we         = 1'b0;
        ld_addr       = '0;
        ld_data       = '0;
        ld_ctrl       = '0;
        start         = 1'b0;
        pkt_len       = '0;
        repeat_cnt    = '0;
        ipg           = '0;
        stream_if.rdy = 1'b1;

        #23;
        check("rst_wr", stream_if.wr, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_pkts", pkts_sent, 64'd0);
        @(negedge clk);
        reset = 1'b0;

        load_word(0, 64'h11, 8'hFF);
        load_word(1, 64'h22, 8'h00);
        load_word(2, 64'h33, 8'h00);
        load_word(3, 64'h44, 8'h01);

        run(4, 1, 0, 0);
        run(4, 1, 0, 2);
        run(3, 3, 2, 0);
        run(3, 2, 0, 0);

        bad_start(0);
        bad_start(257);
        run(4, 1, 0, 0);

        // Asynchronous reset while word 2 of 4 is on the bus.
        @(negedge clk);
        pkt_len       = 9'd4;
        repeat_cnt    = 16'd1;
        ipg           = 8'd0;
        stream_if.rdy = 1'b1;
        start         = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        check("rst_mid_w1", stream_if.data, tb_data[0]);
        @(negedge clk);
        #1;
        check("rst_mid_w2", stream_if.data, tb_data[1]);
        check("rst_mid_wr", stream_if.wr, 1'b1);
        #1;
        reset = 1'b1;
        #1;
        check("async_wr", stream_if.wr, 1'b0);
        check("async_busy", busy, 1'b0);
        check("async_pkts", pkts_sent, 64'd0);
        pkts_exp = 0;
        @(negedge clk);
        reset = 1'b0;
        run(4, 1, 0, 0);

        // Random buffer contents, random shapes and backpressure.
        for (int a = 0; a < DEPTH; a++)
            load_word(a, {$urandom, $urandom}, 8'($urandom));
        run(256, 1, 0, 0);
        run(5, 0, 1, 0);
        for (int i = 0; i < 8; i++)
            run(int'($urandom_range(1, 40)), int'($urandom_range(1, 3)),
                int'($urandom_range(0, 4)), int'($urandom_range(0, 1)));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
